// File: rtl/vga_mode_ctrl_if.sv
// Switch, pixel-counter and colour-output signals of the VGA mode controller.
// master drives the switch and sync-block inputs; slave is the controller itself.
interface vga_mode_ctrl_if;
  logic [2:0] sw;
  logic       auto_en;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [2:0] RGB;
  logic [2:0] mode;
  logic       mode_update;

  modport master (
    output sw, auto_en, video_on, pixel_x, pixel_y,
    input  RGB, mode, mode_update
  );

  modport slave (
    input  sw, auto_en, video_on, pixel_x, pixel_y,
    output RGB, mode, mode_update
  );
endinterface

// File: rtl/vga_mode_ctrl.sv
// Frame-synchronous colour-mode controller: manual or auto-cycling mode, applied at vblank start.
// Define VGA_MODE_BARS_EN to make mode 7 draw vertical colour bars instead of solid white.
module vga_mode_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned V_ACTIVE        = 480
) (
  input logic           clk,
  input logic           reset,
  vga_mode_ctrl_if.slave bus
);

  localparam int unsigned FcntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FcntW-1:0] FcntLast = FcntW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {StManual, StPend, StAuto} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sw_meta_q, sw_s_q;
  logic             auto_meta_q, auto_s_q;
  logic             at_vb_d_q;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [2:0]       target_q, target_d;
  logic             upd_q, upd_d;
  logic [2:0]       rgb_q, rgb_d;

  logic at_vb;
  logic frame_tick;

  // Rising edge of "on first blanking line" gives one tick per frame regardless of pixel rate.
  assign at_vb      = (bus.pixel_y == 10'(V_ACTIVE));
  assign frame_tick = at_vb & ~at_vb_d_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
    upd_d    = 1'b0;
    unique case (state_q)
      StManual: begin
        if (auto_s_q) begin
          state_d = StAuto;
          fcnt_d  = '0;
        end else if (sw_s_q != mode_q) begin
          target_d = sw_s_q;
          state_d  = StPend;
        end
      end
      StPend: begin
        if (auto_s_q) begin
          state_d = StAuto;
          fcnt_d  = '0;
        end else if (frame_tick) begin
          mode_d  = target_q;
          upd_d   = 1'b1;
          state_d = StManual;
        end else begin
          target_d = sw_s_q;
        end
      end
      StAuto: begin
        // Leaving auto wins over a coincident frame tick.
        if (!auto_s_q) begin
          state_d = StManual;
        end else if (frame_tick) begin
          if (fcnt_q == FcntLast) begin
            mode_d = mode_q + 3'd1;
            fcnt_d = '0;
            upd_d  = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: state_d = StManual;
    endcase
  end

  always_comb begin
    rgb_d = 3'b000;
    if (bus.video_on) begin
      if (mode_q != 3'd7) begin
        rgb_d = mode_q;
      end else begin
`ifdef VGA_MODE_BARS_EN
        rgb_d = bus.pixel_x[8:6];
`else
        rgb_d = 3'b111;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StManual;
      sw_meta_q   <= 3'b000;
      sw_s_q      <= 3'b000;
      auto_meta_q <= 1'b0;
      auto_s_q    <= 1'b0;
      at_vb_d_q   <= 1'b0;
      fcnt_q      <= '0;
      mode_q      <= 3'b000;
      target_q    <= 3'b000;
      upd_q       <= 1'b0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= bus.sw;
      sw_s_q      <= sw_meta_q;
      auto_meta_q <= bus.auto_en;
      auto_s_q    <= auto_meta_q;
      at_vb_d_q   <= at_vb;
      fcnt_q      <= fcnt_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      upd_q       <= upd_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.RGB         = rgb_q;
  assign bus.mode        = mode_q;
  assign bus.mode_update = upd_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_vga_mode_ctrl;

  localparam int Fps  = 2;
  localparam int VAct = 480;

  logic clk = 1'b0;
  logic reset;
  vga_mode_ctrl_if bus ();

  vga_mode_ctrl #(
    .FRAMES_PER_STEP(Fps),
    .V_ACTIVE       (VAct)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: flags and integers describing what the controller must be doing.
  int m_mode, m_target, m_frames, m_rgb;
  bit m_pending, m_auto, m_update, m_prev_vb;
  int sw_hist[2];
  bit auto_hist[2];

  function automatic int colour(input bit vo, input int md, input int px);
    if (!vo) return 0;
    if (md < 7) return md;
`ifdef VGA_MODE_BARS_EN
    return (px / 64) % 8;
`else
    return 7;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_target = 0; m_frames = 0; m_rgb = 0;
    m_pending = 0; m_auto = 0; m_update = 0; m_prev_vb = 0;
    sw_hist[0] = 0; sw_hist[1] = 0; auto_hist[0] = 0; auto_hist[1] = 0;
  endtask

  task automatic model_step(input int s_sw, input bit s_auto, input bit s_vo,
                            input int s_px, input int s_py);
    int  sw_s;
    bit  auto_s, tick;
    sw_s     = sw_hist[1];
    auto_s   = auto_hist[1];
    tick     = (s_py == VAct) && !m_prev_vb;
    m_rgb    = colour(s_vo, m_mode, s_px);
    m_update = 0;
    if (m_auto) begin
      if (!auto_s) m_auto = 0;
      else if (tick) begin
        m_frames++;
        if (m_frames == Fps) begin
          m_mode   = (m_mode + 1) % 8;
          m_frames = 0;
          m_update = 1;
        end
      end
    end else if (auto_s) begin
      m_auto    = 1;
      m_pending = 0;
      m_frames  = 0;
    end else if (m_pending) begin
      if (tick) begin
        m_mode    = m_target;
        m_update  = 1;
        m_pending = 0;
      end else m_target = sw_s;
    end else if (sw_s != m_mode) begin
      m_target  = sw_s;
      m_pending = 1;
    end
    m_prev_vb    = (s_py == VAct);
    sw_hist[1]   = sw_hist[0];
    sw_hist[0]   = s_sw;
    auto_hist[1] = auto_hist[0];
    auto_hist[0] = s_auto;
  endtask

  // Inputs change only 1 time unit after a rising edge, so the posedge snapshot is what the DUT saw.
  initial begin
    logic       s_rst, s_auto, s_vo;
    logic [2:0] s_sw;
    logic [9:0] s_px, s_py;
    forever begin
      @(posedge clk);
      s_rst = reset; s_sw = bus.sw; s_auto = bus.auto_en; s_vo = bus.video_on;
      s_px = bus.pixel_x; s_py = bus.pixel_y;
      @(negedge clk);
      if (s_rst || reset) model_reset();
      else model_step(int'(s_sw), s_auto, s_vo, int'(s_px), int'(s_py));
      check("rgb_model", int'(bus.RGB), m_rgb);
      check("mode_model", int'(bus.mode), m_mode);
      check("update_model", int'(bus.mode_update), int'(m_update));
      if (!reset && bus.mode_update) upd_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.pixel_y = 10'd479; cyc(2);
    bus.pixel_y = 10'd480; cyc(2);
    bus.pixel_y = 10'd0;   cyc(2);
  endtask

  int base;
  int exp7;

  initial begin
    reset = 1'b1;
    bus.sw = 3'b101; bus.auto_en = 1'b0; bus.video_on = 1'b1;
    bus.pixel_x = 10'd0; bus.pixel_y = 10'd0;
    cyc(3);
    check("reset_rgb", int'(bus.RGB), 0);
    check("reset_mode", int'(bus.mode), 0);
    check("reset_update", int'(bus.mode_update), 0);

    // Pending switch value 5 must wait for the frame tick.
    reset = 1'b0;
    cyc(3);
    check("pend_hold_mode", int'(bus.mode), 0);
    cyc(5);
    check("pend_hold_mode2", int'(bus.mode), 0);
    frame();
    check("first_apply_mode", int'(bus.mode), 5);

    // Manual apply of 3.
    bus.sw = 3'b011; cyc(4);
    bus.pixel_y = 10'd479; cyc(1);
    bus.pixel_y = 10'd480; cyc(1);
    check("manual_mode", int'(bus.mode), 3);
    check("manual_update_hi", int'(bus.mode_update), 1);
    cyc(1);
    check("manual_update_lo", int'(bus.mode_update), 0);
    check("manual_rgb", int'(bus.RGB), 3);
    cyc(2);
    bus.pixel_y = 10'd0; cyc(2);

    // Latest switch value wins, single update pulse.
    base = upd_cnt;
    bus.sw = 3'b010; cyc(4);
    bus.sw = 3'b110; cyc(4);
    frame();
    check("latest_mode", int'(bus.mode), 6);
    check("latest_pulses", upd_cnt - base, 1);
    check("latest_rgb", int'(bus.RGB), 6);

    bus.video_on = 1'b0; cyc(2);
    check("blank_rgb", int'(bus.RGB), 0);
    bus.video_on = 1'b1;

    // Mode 7 colour at x = 200.
    bus.sw = 3'b111; cyc(4);
    frame();
    check("mode7_mode", int'(bus.mode), 7);
    bus.pixel_x = 10'd200; cyc(2);
`ifdef VGA_MODE_BARS_EN
    exp7 = 3;
`else
    exp7 = 7;
`endif
    check("mode7_rgb", int'(bus.RGB), exp7);
    bus.video_on = 1'b0; cyc(2);
    check("mode7_blank_rgb", int'(bus.RGB), 0);
    bus.video_on = 1'b1;

    // Auto mode, two frames per step: 7 -> 0 -> 1.
    bus.sw = 3'b001;
    bus.auto_en = 1'b1; cyc(3);
    frame();
    check("auto_one_tick", int'(bus.mode), 7);
    frame();
    check("auto_wrap", int'(bus.mode), 0);
    frame();
    frame();
    check("auto_step", int'(bus.mode), 1);

    // auto_s falls on the same edge as the step-eligible frame tick.
    frame();
    base = upd_cnt;
    bus.pixel_y = 10'd479;
    bus.auto_en = 1'b0; cyc(2);
    bus.pixel_y = 10'd480; cyc(1);
    check("simul_no_step", int'(bus.mode), 1);
    cyc(2);
    bus.pixel_y = 10'd0; cyc(2);
    frame();
    check("simul_manual_mode", int'(bus.mode), 1);
    check("simul_no_pulse", upd_cnt - base, 0);

    // Reset in the middle of auto mode.
    bus.auto_en = 1'b1; cyc(4);
    frame(); frame();
    check("pre_reset_mode", int'(bus.mode), 2);
    reset = 1'b1; cyc(1);
    check("midauto_reset_mode", int'(bus.mode), 0);
    check("midauto_reset_rgb", int'(bus.RGB), 0);
    bus.auto_en = 1'b0;
    cyc(1);
    reset = 1'b0; cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
# vga_mode_ctrl

Frame-synchronous colour-mode controller for the VGA output path. Selects the active colour mode either manually from the board switches or automatically by stepping through all modes every fixed number of frames. Mode changes are applied only at the start of vertical blanking, so a frame is never drawn with mixed modes. Sits between the switch inputs, the sync/pixel-counter block (`pixel_x`, `pixel_y`, `video_on`) and the 3-bit RGB output pins.

## Interface
- `FRAMES_PER_STEP`, 60: frames per mode step in auto mode; must be ≥ 1.
- `V_ACTIVE`, 480: number of visible lines; line `V_ACTIVE` is the first blanking line.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sw` in 3: requested manual mode; asynchronous to `clk`.
- `auto_en` in 1: selects auto-cycle mode; asynchronous to `clk`.
- `video_on` in 1: visible-area flag from the sync block.
- `pixel_x` in 10: current pixel column.
- `pixel_y` in 10: current pixel line.
- `RGB` out 3: registered colour output.
- `mode` out 3: currently applied mode.
- `mode_update` out 1: one-cycle pulse on the cycle after `mode` changes.

## Operation
- `sw` and `auto_en` each pass through a 2-flop synchroniser, giving `sw_s` and `auto_s`.
- Frame tick:
  - `at_vb = (pixel_y == V_ACTIVE)`, registered as `at_vb_d`.
  - `frame_tick = at_vb & ~at_vb_d`, giving exactly one pulse per frame independent of the pixel-tick rate.
- The frame counter `fcnt` is `$clog2(FRAMES_PER_STEP)` bits wide, with a minimum width of 1.
- FSM states are MANUAL, PEND and AUTO. Reset state is MANUAL.
- **MANUAL**
  - If `auto_s`, go to AUTO and set `fcnt <= 0`.
  - Otherwise, if `sw_s != mode`, set `target <= sw_s` and go to PEND.
- **PEND**
  - If `auto_s`, go to AUTO, drop the pending target and set `fcnt <= 0`.
  - Otherwise, on `frame_tick`, set `mode <= target`, pulse `mode_update` and go to MANUAL.
  - With no `frame_tick`, `target <= sw_s` every cycle, so the latest switch value wins.
- **AUTO**
  - If `!auto_s`, go to MANUAL with no step taken, even if `frame_tick` occurs in the same cycle.
  - Otherwise, on `frame_tick`:
    - If `fcnt == FRAMES_PER_STEP-1`, set `mode <= mode + 1` (7 wraps to 0), set `fcnt <= 0` and pulse `mode_update`.
    - Else set `fcnt <= fcnt + 1`.
- Colour generation, registered:
  - `RGB <= 0` when `!video_on`.
  - Otherwise, modes 0–6 give `RGB <= mode` (solid colour).
  - Mode 7 is set by configuration (see Configuration).

## Timing
- Reset values: `RGB = 0`, `mode = 0`, `mode_update = 0`, `fcnt = 0`, `target = 0`, FSM in MANUAL, synchronisers and `at_vb_d` cleared.
- Assertion of `reset` at any time, including mid-PEND or mid-AUTO, immediately returns every register to its reset value.
- `RGB` latency is 1 `clk` from `video_on`, `pixel_x` and `mode`.
- `sw` to PEND entry takes 3 `clk` edges: 2 synchroniser edges plus 1 FSM edge.
- `mode` changes on the `clk` edge where `frame_tick` is high in PEND or AUTO. `mode_update` is high for exactly the following cycle.
- In MANUAL with `sw_s == mode`, nothing changes. Returning `sw` to the current `mode` while in PEND still applies that same value at the next tick, and `mode_update` still pulses.
- With `FRAMES_PER_STEP = 1`, auto mode steps on every `frame_tick`.

## Configuration
- `VGA_MODE_BARS_EN` defined: mode 7 produces vertical colour bars, `RGB <= pixel_x[8:6]` (eight 64-pixel bars, repeating after x = 511).
- Macro undefined: mode 7 is solid white, `RGB <= 3'b111`, and no `pixel_x` logic is synthesised.

## Test plan
- Reset with `sw = 3'b101` and `video_on = 1` → `RGB = 0`, `mode = 0`. After release, 3 clocks later the FSM is in PEND, but `mode` stays 0 until the frame tick.
- Manual apply: `sw = 3'b011`, then `pixel_y` steps 479 → 480 (held 4 clk) → `mode = 3` after the first 480 cycle, `mode_update` high for one cycle only, and `RGB = 3'b011` while `video_on`.
- Latest wins: `sw` goes 010 then 110 before the tick → `mode = 6` at the tick, with a single `mode_update`.
- Auto mode: `FRAMES_PER_STEP = 2`, `auto_en = 1`, `mode = 7` → after 2 frame ticks `mode = 0` (wrap). After 4 ticks `mode = 1`.
- Simultaneous event: `auto_en` deasserted so that `auto_s` falls in the same cycle as `frame_tick` with `fcnt = 1` → no step, state MANUAL, `mode` unchanged.
- Mode 7 with `video_on = 1` and `pixel_x = 200` → `RGB = 3'b011` with `VGA_MODE_BARS_EN`, and `3'b111` without it. `video_on = 0` gives `RGB = 0` in every mode.
